// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM block types and default sizing
package pwm_pkg;

    localparam int PWM_DEFAULT_DW       = 8;
    localparam int PWM_DEFAULT_FILT_LEN = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        STUCK = 2'd3
    } pwm_cap_state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// rtl/pwm_edge_sync.sv - pwm_in synchronizer and edge detect; glitch filter under PWM_CAPTURE_FILTER_EN
module pwm_edge_sync #(
    parameter int FILT_LEN = 3
) (
    input  logic slow_clk,
    input  logic ARESETN,
    input  logic pwm_in,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s3_q, s3_d;
    logic mid;

    assign s1_d = pwm_in;
    assign s3_d = mid;

    always_ff @(posedge slow_clk or negedge ARESETN) begin
        if (!ARESETN) begin
            s1_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s3_q <= s3_d;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic           filt_q, filt_d;
    logic [FCW-1:0] cnt_q, cnt_d;

    // Any return of s1 to the filtered level restarts the stability count.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (s1_q != filt_q) begin
            if (cnt_q == FCW'(FILT_LEN - 1)) begin
                filt_d = s1_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge slow_clk or negedge ARESETN) begin
        if (!ARESETN) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign mid = filt_q;
`else
    logic s2_q, s2_d;
    logic unused_filt_len;

    assign s2_d            = s1_q;
    assign unused_filt_len = (FILT_LEN > 0);

    always_ff @(posedge slow_clk or negedge ARESETN) begin
        if (!ARESETN) begin
            s2_q <= 1'b0;
        end else begin
            s2_q <= s2_d;
        end
    end

    assign mid = s2_q;
`endif

    assign lvl  = mid;
    assign rise = mid & ~s3_q;
    assign fall = ~mid & s3_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time/period capture with stuck-line timeout; filter via PWM_CAPTURE_FILTER_EN
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int DW       = PWM_DEFAULT_DW,
    parameter int CW       = DW + 1,
    parameter int FILT_LEN = PWM_DEFAULT_FILT_LEN
) (
    input  logic          slow_clk,
    input  logic          ARESETN,
    input  logic          pwm_in,
    output logic [CW-1:0] high_cnt,
    output logic [CW-1:0] period,
    output logic          valid,
    output logic          timeout,
    output logic          level
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic lvl, rise, fall;

    pwm_edge_sync #(.FILT_LEN(FILT_LEN)) u_edge_sync (
        .slow_clk (slow_clk),
        .ARESETN  (ARESETN),
        .pwm_in   (pwm_in),
        .lvl      (lvl),
        .rise     (rise),
        .fall     (fall)
    );

    pwm_cap_state_t state_q, state_d;
    logic [CW-1:0]  hi_ctr_q, hi_ctr_d;
    logic [CW-1:0]  per_ctr_q, per_ctr_d;
    logic [CW-1:0]  hi_lat_q, hi_lat_d;
    logic [CW-1:0]  high_cnt_q, high_cnt_d;
    logic [CW-1:0]  period_q, period_d;
    logic           valid_q, valid_d;
    logic           timeout_q, timeout_d;
    logic           level_q, level_d;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Edge checks precede the saturation check so an edge always wins.
    // IDLE also counts so a line dead since reset still reports timeout.
    always_comb begin
        state_d    = state_q;
        hi_ctr_d   = hi_ctr_q;
        per_ctr_d  = per_ctr_q;
        hi_lat_d   = hi_lat_q;
        high_cnt_d = high_cnt_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        timeout_d  = timeout_q;
        level_d    = level_q;
        case (state_q)
            IDLE: begin
                per_ctr_d = sat_inc(per_ctr_q);
                if (rise) begin
                    state_d   = HIGH;
                    hi_ctr_d  = ONE;
                    per_ctr_d = ONE;
                end else if (fall) begin
                    per_ctr_d = ONE;
                end else if (per_ctr_q == CNT_MAX) begin
                    state_d   = STUCK;
                    timeout_d = 1'b1;
                    level_d   = lvl;
                end
            end
            HIGH: begin
                hi_ctr_d  = sat_inc(hi_ctr_q);
                per_ctr_d = sat_inc(per_ctr_q);
                if (fall) begin
                    hi_lat_d = hi_ctr_q;
                    state_d  = LOW;
                end else if (per_ctr_q == CNT_MAX) begin
                    state_d   = STUCK;
                    timeout_d = 1'b1;
                    level_d   = lvl;
                end
            end
            LOW: begin
                per_ctr_d = sat_inc(per_ctr_q);
                if (rise) begin
                    period_d   = per_ctr_q;
                    high_cnt_d = hi_lat_q;
                    valid_d    = 1'b1;
                    per_ctr_d  = ONE;
                    hi_ctr_d   = ONE;
                    state_d    = HIGH;
                end else if (per_ctr_q == CNT_MAX) begin
                    state_d   = STUCK;
                    timeout_d = 1'b1;
                    level_d   = lvl;
                end
            end
            STUCK: begin
                if (rise) begin
                    state_d   = HIGH;
                    hi_ctr_d  = ONE;
                    per_ctr_d = ONE;
                    timeout_d = 1'b0;
                end else if (fall) begin
                    state_d   = IDLE;
                    per_ctr_d = ONE;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge slow_clk or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            hi_ctr_q   <= '0;
            per_ctr_q  <= '0;
            hi_lat_q   <= '0;
            high_cnt_q <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            level_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_ctr_q   <= hi_ctr_d;
            per_ctr_q  <= per_ctr_d;
            hi_lat_q   <= hi_lat_d;
            high_cnt_q <= high_cnt_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            level_q    <= level_d;
        end
    end

    assign high_cnt = high_cnt_q;
    assign period   = period_q;
    assign valid    = valid_q;
    assign timeout  = timeout_q;
    assign level    = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture against a segment-list reference model
module tb_pwm_capture;

    localparam int CW = 9;

    logic          slow_clk = 1'b0;
    logic          ARESETN  = 1'b0;
    logic          pwm_in   = 1'b0;
    logic [CW-1:0] high_cnt, period;
    logic          valid, timeout, level;

    pwm_capture #(.DW(8), .CW(CW), .FILT_LEN(3)) dut (
        .slow_clk (slow_clk),
        .ARESETN  (ARESETN),
        .pwm_in   (pwm_in),
        .high_cnt (high_cnt),
        .period   (period),
        .valid    (valid),
        .timeout  (timeout),
        .level    (level)
    );

    always #5 slow_clk = ~slow_clk;

    int passed = 0;
    int total  = 0;
    bit saw_timeout;

    logic [CW-1:0] got_h[$], got_p[$], exp_h[$], exp_p[$];
    int            seg_h[$], seg_l[$];

    always @(negedge slow_clk) begin
        if (ARESETN === 1'b1 && valid === 1'b1) begin
            got_h.push_back(high_cnt);
            got_p.push_back(period);
        end
        if (ARESETN === 1'b1 && timeout === 1'b1) saw_timeout = 1'b1;
    end

    task automatic tick();
        @(posedge slow_clk);
        #1;
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        pwm_in  = 1'b0;
        repeat (3) tick();
        ARESETN = 1'b1;
        got_h.delete();
        got_p.delete();
        saw_timeout = 1'b0;
    endtask

    // Each rise closes the previous high+low pair; the first rise only opens one.
    task automatic build_expect(input bit trailing_rise);
        exp_h.delete();
        exp_p.delete();
        for (int i = 0; i < seg_h.size(); i++) begin
            if (i < seg_h.size() - 1 || trailing_rise) begin
                exp_h.push_back(CW'(seg_h[i]));
                exp_p.push_back(CW'(seg_h[i] + seg_l[i]));
            end
        end
    endtask

    task automatic drive_segs();
        for (int i = 0; i < seg_h.size(); i++) begin
            pwm_in = 1'b1;
            repeat (seg_h[i]) tick();
            pwm_in = 1'b0;
            repeat (seg_l[i]) tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        total++;
        if (high_cnt !== '0) $display("FAIL reset_high_cnt: got %0d want 0", high_cnt); else passed++;
        total++;
        if (period !== '0) $display("FAIL reset_period: got %0d want 0", period); else passed++;
        total++;
        if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else passed++;
        total++;
        if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else passed++;
        total++;
        if (level !== 1'b0) $display("FAIL reset_level: got %b want 0", level); else passed++;
    endtask

    task automatic test_loopback();
        do_reset();
        seg_h.delete(); seg_l.delete();
        for (int i = 0; i < 6; i++) begin
            seg_h.push_back(256 - 64);
            seg_l.push_back(64);
        end
        build_expect(1'b0);
        drive_segs();
        repeat (6) tick();
        total++;
        if (got_h.size() != exp_h.size())
            $display("FAIL loopback_count: got %0d results want %0d", got_h.size(), exp_h.size());
        else passed++;
        for (int i = 0; i < exp_h.size() && i < got_h.size(); i++) begin
            total++;
            if (got_h[i] !== exp_h[i] || got_p[i] !== exp_p[i])
                $display("FAIL loopback_result[%0d]: got high=%0d period=%0d want high=%0d period=%0d",
                         i, got_h[i], got_p[i], exp_h[i], exp_p[i]);
            else passed++;
        end
    endtask

    task automatic test_duty_sweep();
        int duties[3];
        int cnt;
`ifdef PWM_CAPTURE_FILTER_EN
        duties = '{4, 128, 252};
`else
        duties = '{1, 128, 255};
`endif
        do_reset();
        seg_h.delete(); seg_l.delete();
        foreach (duties[k]) begin
            for (int j = 0; j < 4; j++) begin
                seg_h.push_back(256 - duties[k]);
                seg_l.push_back(duties[k]);
            end
        end
        build_expect(1'b1);
        drive_segs();
        pwm_in = 1'b1;
        cnt = 0;
        while (timeout !== 1'b1 && cnt < 700) begin
            tick();
            cnt++;
        end
        total++;
        if (cnt < 505 || cnt > 525) $display("FAIL stuck_high_timeout_cycles: got %0d want 505..525", cnt); else passed++;
        total++;
        if (level !== 1'b1) $display("FAIL stuck_high_level: got %b want 1", level); else passed++;
        total++;
        if (got_h.size() != exp_h.size())
            $display("FAIL sweep_count: got %0d results want %0d", got_h.size(), exp_h.size());
        else passed++;
        for (int i = 0; i < exp_h.size() && i < got_h.size(); i++) begin
            total++;
            if (got_h[i] !== exp_h[i] || got_p[i] !== exp_p[i])
                $display("FAIL sweep_result[%0d]: got high=%0d period=%0d want high=%0d period=%0d",
                         i, got_h[i], got_p[i], exp_h[i], exp_p[i]);
            else passed++;
        end
        total++;
        if (high_cnt !== exp_h[exp_h.size()-1] || period !== exp_p[exp_p.size()-1])
            $display("FAIL stuck_hold: got high=%0d period=%0d want high=%0d period=%0d",
                     high_cnt, period, exp_h[exp_h.size()-1], exp_p[exp_p.size()-1]);
        else passed++;
    endtask

    task automatic test_dead_line();
        int cnt;
        do_reset();
        cnt = 0;
        while (timeout !== 1'b1 && cnt < 700) begin
            tick();
            cnt++;
        end
        total++;
        if (cnt < 505 || cnt > 525) $display("FAIL dead_timeout_cycles: got %0d want 505..525", cnt); else passed++;
        total++;
        if (level !== 1'b0) $display("FAIL dead_level: got %b want 0", level); else passed++;
        total++;
        if (got_h.size() != 0) $display("FAIL dead_no_valid: got %0d results want 0", got_h.size()); else passed++;
        seg_h.delete(); seg_l.delete();
        for (int i = 0; i < 3; i++) begin
            seg_h.push_back(10);
            seg_l.push_back(20);
        end
        build_expect(1'b0);
        pwm_in = 1'b1;
        repeat (8) tick();
        total++;
        if (timeout !== 1'b0) $display("FAIL dead_timeout_clear: got %b want 0", timeout); else passed++;
        repeat (2) tick();
        pwm_in = 1'b0;
        repeat (20) tick();
        for (int i = 1; i < 3; i++) begin
            pwm_in = 1'b1;
            repeat (seg_h[i]) tick();
            pwm_in = 1'b0;
            repeat (seg_l[i]) tick();
        end
        repeat (6) tick();
        total++;
        if (got_h.size() != exp_h.size())
            $display("FAIL dead_recover_count: got %0d results want %0d", got_h.size(), exp_h.size());
        else passed++;
        for (int i = 0; i < exp_h.size() && i < got_h.size(); i++) begin
            total++;
            if (got_h[i] !== exp_h[i] || got_p[i] !== exp_p[i])
                $display("FAIL dead_recover_result[%0d]: got high=%0d period=%0d want high=%0d period=%0d",
                         i, got_h[i], got_p[i], exp_h[i], exp_p[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        seg_h.delete(); seg_l.delete();
        for (int i = 0; i < 2; i++) begin
            seg_h.push_back(int'($urandom_range(120, 20)));
            seg_l.push_back(int'($urandom_range(120, 20)));
        end
        drive_segs();
        pwm_in = 1'b1;
        repeat (30) tick();
        ARESETN = 1'b0;
        #1;
        total++;
        if ({high_cnt, period, valid, timeout, level} !== '0)
            $display("FAIL midreset_outputs: got high=%0d period=%0d valid=%b timeout=%b level=%b want all 0",
                     high_cnt, period, valid, timeout, level);
        else passed++;
        repeat (2) tick();
        pwm_in  = 1'b0;
        ARESETN = 1'b1;
        got_h.delete(); got_p.delete();
        repeat (10) tick();
        total++;
        if ({high_cnt, period, timeout} !== '0)
            $display("FAIL midreset_release: got high=%0d period=%0d timeout=%b want all 0", high_cnt, period, timeout);
        else passed++;
        seg_h.delete(); seg_l.delete();
        for (int i = 0; i < 4; i++) begin
            seg_h.push_back(int'($urandom_range(200, 5)));
            seg_l.push_back(int'($urandom_range(200, 5)));
        end
        build_expect(1'b0);
        drive_segs();
        repeat (6) tick();
        total++;
        if (got_h.size() != exp_h.size())
            $display("FAIL midreset_count: got %0d results want %0d", got_h.size(), exp_h.size());
        else passed++;
        for (int i = 0; i < exp_h.size() && i < got_h.size(); i++) begin
            total++;
            if (got_h[i] !== exp_h[i] || got_p[i] !== exp_p[i])
                $display("FAIL midreset_result[%0d]: got high=%0d period=%0d want high=%0d period=%0d",
                         i, got_h[i], got_p[i], exp_h[i], exp_p[i]);
            else passed++;
        end
    endtask

    task automatic test_random();
        do_reset();
        seg_h.delete(); seg_l.delete();
        seg_h.push_back(3);
        seg_l.push_back(3);
        for (int i = 0; i < 8; i++) begin
            seg_h.push_back(int'($urandom_range(300, 3)));
            seg_l.push_back(int'($urandom_range(200, 3)));
        end
        build_expect(1'b0);
        drive_segs();
        repeat (6) tick();
        total++;
        if (got_h.size() != exp_h.size())
            $display("FAIL random_count: got %0d results want %0d", got_h.size(), exp_h.size());
        else passed++;
        for (int i = 0; i < exp_h.size() && i < got_h.size(); i++) begin
            total++;
            if (got_h[i] !== exp_h[i] || got_p[i] !== exp_p[i])
                $display("FAIL random_result[%0d]: got high=%0d period=%0d want high=%0d period=%0d",
                         i, got_h[i], got_p[i], exp_h[i], exp_p[i]);
            else passed++;
        end
    endtask

    task automatic test_saturation_edge();
        do_reset();
        seg_h.delete(); seg_l.delete();
        for (int i = 0; i < 3; i++) begin
            seg_h.push_back(311);
            seg_l.push_back(200);
        end
        seg_h.push_back(10);
        seg_l.push_back(10);
        build_expect(1'b0);
        drive_segs();
        repeat (6) tick();
        total++;
        if (saw_timeout !== 1'b0) $display("FAIL sat_edge_timeout: got %b want 0", saw_timeout); else passed++;
        total++;
        if (got_h.size() != exp_h.size())
            $display("FAIL sat_edge_count: got %0d results want %0d", got_h.size(), exp_h.size());
        else passed++;
        for (int i = 0; i < exp_h.size() && i < got_h.size(); i++) begin
            total++;
            if (got_h[i] !== exp_h[i] || got_p[i] !== exp_p[i])
                $display("FAIL sat_edge_result[%0d]: got high=%0d period=%0d want high=%0d period=%0d",
                         i, got_h[i], got_p[i], exp_h[i], exp_p[i]);
            else passed++;
        end
    endtask

    task automatic test_jitter();
        longint t;
        int     d;
        int     dh, dp;
        do_reset();
        t = longint'($time) + 50;
        for (int i = 0; i < 6; i++) begin
            d = int'($urandom_range(7, 0)) - 4;
            if (d >= 0) d++;
            #(t + d - longint'($time));
            pwm_in = 1'b1;
            t += 100 * 10;
            d = int'($urandom_range(7, 0)) - 4;
            if (d >= 0) d++;
            #(t + d - longint'($time));
            pwm_in = 1'b0;
            t += 156 * 10;
        end
        tick();
        repeat (6) tick();
        total++;
        if (got_h.size() != 5) $display("FAIL jitter_count: got %0d results want 5", got_h.size()); else passed++;
        for (int i = 0; i < got_h.size(); i++) begin
            dh = int'(got_h[i]) - 100;
            dp = int'(got_p[i]) - 256;
            total++;
            if (dh < -1 || dh > 1 || dp < -1 || dp > 1)
                $display("FAIL jitter_result[%0d]: got high=%0d period=%0d want high=100+/-1 period=256+/-1",
                         i, got_h[i], got_p[i]);
            else passed++;
        end
    endtask

    task automatic test_glitch();
        do_reset();
        seg_h.delete(); seg_l.delete();
        for (int i = 0; i < 4; i++) begin
            seg_h.push_back(50); seg_l.push_back(2);
            seg_h.push_back(76); seg_l.push_back(50);
            seg_h.push_back(2);  seg_l.push_back(76);
        end
        drive_segs();
        repeat (6) tick();
`ifdef PWM_CAPTURE_FILTER_EN
        seg_h.delete(); seg_l.delete();
        for (int i = 0; i < 4; i++) begin
            seg_h.push_back(128);
            seg_l.push_back(128);
        end
`endif
        build_expect(1'b0);
        total++;
        if (got_h.size() != exp_h.size())
            $display("FAIL glitch_count: got %0d results want %0d", got_h.size(), exp_h.size());
        else passed++;
        for (int i = 0; i < exp_h.size() && i < got_h.size(); i++) begin
            total++;
            if (got_h[i] !== exp_h[i] || got_p[i] !== exp_p[i])
                $display("FAIL glitch_result[%0d]: got high=%0d period=%0d want high=%0d period=%0d",
                         i, got_h[i], got_p[i], exp_h[i], exp_p[i]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_duty_sweep();
        test_dead_line();
        test_reset_mid();
        test_random();
        test_saturation_edge();
        test_jitter();
        test_glitch();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passed, total);
        $fatal(1, "time limit");
    end

endmodule
